sixty_four_bit_shift_register: RTL and testbench



---
 rtl/sixty_four_bit_shift_register_pkg.sv | 18 +
 rtl/sixty_four_bit_shift_register_if.sv | 28 ++
 rtl/sixty_four_bit_shift_register_adder.sv | 43 ++++
 rtl/sixty_four_bit_shift_register.sv | 33 +++
 tb/tb_sixty_four_bit_shift_register.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sixty_four_bit_shift_register_pkg.sv
// Shared constants for the program-counter datapath: default width and
// register mode encoding taken from {shiftLeft, shiftRight}.
package sixty_four_bit_shift_register_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    HOLD = 2'b11
  } mode_e;

  function automatic mode_e decode_mode(input logic shift_left, input logic shift_right);
    return mode_e'({shift_left, shift_right});
  endfunction

endpackage

// File: rtl/sixty_four_bit_shift_register_if.sv
// Register data/command bus. Not a handshake: commands are sampled every
// rising clock edge and `out` is the registered value, valid every cycle.
interface sixty_four_bit_shift_register_if
  import sixty_four_bit_shift_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] in;
  logic             shiftLeft;
  logic             shiftRight;
  logic [WIDTH-1:0] out;

  modport master (
    output in,
    output shiftLeft,
    output shiftRight,
    input  out
  );

  modport slave (
    input  in,
    input  shiftLeft,
    input  shiftRight,
    output out
  );

endinterface

// File: rtl/sixty_four_bit_shift_register_adder.sv
// Ripple-carry adder for the PC increment path; instantiated beside the
// register at the datapath level, not inside it.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder
  import sixty_four_bit_shift_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0]  = carry_in;
  assign carry_out = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/sixty_four_bit_shift_register.sv
// WIDTH-bit load/shift register holding the program counter; async
// active-low reset clears it to zero immediately.
module sixty_four_bit_shift_register
  import sixty_four_bit_shift_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic clock,
  input logic reset,
  sixty_four_bit_shift_register_if.slave bus
);

  logic [WIDTH-1:0] value;
  mode_e            mode;

  assign mode    = decode_mode(bus.shiftLeft, bus.shiftRight);
  assign bus.out = value;

  // Shifted-out bits are simply dropped; there is no serial output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else begin
      case (mode)
        LOAD:    value <= bus.in;
        SHL:     value <= {value[WIDTH-2:0], 1'b0};
        SHR:     value <= {1'b0, value[WIDTH-1:1]};
        default: value <= value;
      endcase
    end
  end

endmodule

// File: tb/tb_sixty_four_bit_shift_register.sv
// Directed bench for the PC register and its companion adder, including the
// closed out->a, sum->in program-counter loop.
module tb_sixty_four_bit_shift_register;

  localparam int W = 64;
  localparam logic [1:0] M_LOAD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
  } reg_vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } add_vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic         pc_mode = 1'b0;
  logic [W-1:0] in_drv  = '0;
  logic [W-1:0] a_drv   = '0;
  logic [W-1:0] b_drv   = '0;
  logic         cin_drv = 1'b0;

  logic [W-1:0] a;
  logic [W-1:0] sum;
  logic         carry_out;

  int errors = 0;
  int checks = 0;

  sixty_four_bit_shift_register_if #(.WIDTH(W)) bus ();

  sixty_four_bit_shift_register #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  adder #(.WIDTH(W)) u_adder (
    .a         (a),
    .b         (b_drv),
    .carry_in  (cin_drv),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Datapath wiring: in PC mode the register feeds the adder and back.
  assign a      = pc_mode ? bus.out : a_drv;
  assign bus.in = pc_mode ? sum : in_drv;

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic set_mode(input logic [1:0] m);
    bus.shiftLeft  = m[1];
    bus.shiftRight = m[0];
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge happen, sample on the next falling edge.
  task automatic step(input logic [1:0] m, input logic [W-1:0] d);
    set_mode(m);
    in_drv = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  reg_vec_t reg_vecs[12];
  add_vec_t add_vecs[5];

  initial begin
    reg_vecs[0]  = '{M_LOAD, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    reg_vecs[1]  = '{M_HOLD, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
    reg_vecs[2]  = '{M_HOLD, 64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF};
    reg_vecs[3]  = '{M_HOLD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
    reg_vecs[4]  = '{M_LOAD, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    reg_vecs[5]  = '{M_SHL,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002};
    reg_vecs[6]  = '{M_LOAD, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    reg_vecs[7]  = '{M_SHR,  64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000};
    reg_vecs[8]  = '{M_SHL,  64'h1234_0000_0000_0000, 64'h8000_0000_0000_0000};
    reg_vecs[9]  = '{M_SHL,  64'h1234_0000_0000_0000, 64'h0000_0000_0000_0000};
    reg_vecs[10] = '{M_LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    reg_vecs[11] = '{M_SHR,  64'h0000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

    add_vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
    add_vecs[1] = '{64'd5, 64'd7, 1'b1, 64'd13, 1'b0};
    add_vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    add_vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    add_vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                    64'h1234_5678_9ABC_DF00, 1'b0};

    // ---------------- reset held ----------------
    set_mode(M_LOAD);
    in_drv = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("reset_initial", bus.out, '0);
    repeat (3) @(negedge clock);
    check("reset_held_load", bus.out, '0);

    // ---------------- register vectors ----------------
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(reg_vecs[i].mode, reg_vecs[i].din);
      check($sformatf("reg_vec%0d", i), bus.out, reg_vecs[i].exp_out);
    end

    // ---------------- async reset mid-cycle ----------------
    step(M_LOAD, 64'hA5A5_A5A5_A5A5_A5A5);
    check("pre_async_load", bus.out, 64'hA5A5_A5A5_A5A5_A5A5);
    #2 reset = 1'b0;
    #1;
    check("async_reset_clear", bus.out, '0);
    @(negedge clock);
    check("async_reset_held", bus.out, '0);
    reset = 1'b1;
    step(M_LOAD, 64'h0000_0000_0000_0042);
    check("after_release", bus.out, 64'h42);

    // ---------------- adder vectors ----------------
    for (int i = 0; i < 5; i++) begin
      a_drv   = add_vecs[i].a;
      b_drv   = add_vecs[i].b;
      cin_drv = add_vecs[i].cin;
      #1;
      check($sformatf("add_sum%0d", i), sum, add_vecs[i].exp_sum);
      check($sformatf("add_cout%0d", i), {63'd0, carry_out}, {63'd0, add_vecs[i].exp_cout});
    end

    // ---------------- PC loop from reset ----------------
    @(negedge clock);
    reset   = 1'b0;
    pc_mode = 1'b1;
    b_drv   = 64'd4;
    cin_drv = 1'b0;
    set_mode(M_LOAD);
    #1;
    check("pc_reset_out", bus.out, '0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("pc_step%0d", i), bus.out, 64'(4 * i));
    end

    // ---------------- PC wrap ----------------
    pc_mode = 1'b0;
    step(M_LOAD, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_preload", bus.out, 64'hFFFF_FFFF_FFFF_FFFC);
    pc_mode = 1'b1;
    #1;
    check("wrap_sum_before", sum, '0);
    check("wrap_cout_before", {63'd0, carry_out}, 64'd1);
    @(posedge clock);
    @(negedge clock);
    check("wrap_out", bus.out, '0);
    check("wrap_cout_after", {63'd0, carry_out}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("wrap_next", bus.out, 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
